alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencer and arbiter that shares the single combinational `alu` between two requesters. Each requester presents operands and a 3-bit op through a valid/ready handshake. The block grants one request at a time, drives the ALU from registered operands, and captures `out` and the 8-bit `flags`. It returns them on one response channel with backpressure, tagged with the requester id. It sits between the instruction-issue logic and the ALU, so the ALU keeps its pure combinational contract.

## Interface
Parameters:
- FAIR, 1: 1 = round-robin grant; 0 = fixed priority, req0 always wins.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  8  requester 0 operands.
- req0_op  in  3  requester 0 ALU op code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_a, alu_b  out  8  to ALU `a`, `b`.
- alu_op  out  3  to ALU `op`.
- alu_out  in  8  from ALU `out`.
- alu_flags  in  8  from ALU `flags`; the block passes these through uninterpreted.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_out  out  8  captured ALU result.
- rsp_flags  out  8  captured ALU flags.
- op_count  out  CNT_W  completed responses, modulo 2^CNT_W.

## Operation
- State machine: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant is combinational from the valids and the priority pointer `last`.
  - `reqN_ready` = (state==IDLE) && grant==N. At most one ready is high.
  - FAIR=1: if both are valid, grant goes to the requester other than `last`; a single valid requester is granted regardless. FAIR=0: req0 wins whenever it is valid.
  - On handshake (`reqN_valid && reqN_ready` at an edge): latch the operands/op into `alu_a`/`alu_b`/`alu_op`, latch the id, set `last`=N, go to EXEC.
  - With no valid requester, stay in IDLE.
- EXEC: lasts one cycle. At the next edge, capture `alu_out`→`rsp_out`, `alu_flags`→`rsp_flags` and id→`rsp_id`, set `rsp_valid`=1, go to RESP.
- RESP:
  - Hold `rsp_valid` and all rsp fields stable while `rsp_ready`=0.
  - On the edge with `rsp_ready`=1: clear `rsp_valid`, increment `op_count` (wraps to 0 at 2^CNT_W), go to IDLE.
- ALU sampling: `alu_*` outputs change only on an IDLE handshake and otherwise hold their last values. The block samples ALU outputs only at the EXEC→RESP edge.
- Request inputs are ignored outside IDLE. Requesters must hold their valid and data until ready.

## Timing
- Reset values (immediate on `rst_n`=0, independent of clk):
  - state=IDLE, `last`=1 (req0 favoured first).
  - `alu_a`=`alu_b`=0, `alu_op`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_out`=0, `rsp_flags`=0, `op_count`=0.
  - ready outputs follow IDLE decode.
- Latency, with the handshake at edge T:
  - `rsp_valid` is high after edge T+1.
  - With `rsp_ready`=1 held, the block is back in IDLE after T+2.
  - The next handshake is possible at T+3, giving a peak throughput of one operation per 3 cycles.
- Reset asserted in EXEC or RESP drops the in-flight operation: no response is produced and `op_count` is not incremented.
- `rsp_ready` high while `rsp_valid`=0 has no effect.

## Test plan
- Bench ALU stub: `alu_out` = `alu_a ^ alu_b`, `alu_flags` = {5'b0, `alu_op`}.
- Single operation: req0 with a=8'h12, b=8'h34, op=3'd2, and `rsp_ready`=1.
  - Required: `req0_ready`=1 in the accept cycle.
  - Required: one cycle later `rsp_valid`=1 with `rsp_out`=8'h26, `rsp_flags`=8'h02, `rsp_id`=0.
  - Required: `op_count`=1 after the response.
- Round-robin (FAIR=1): both requesters continuously valid, req0 a=8'h01, req1 a=8'h02, b=0.
  - Required: `rsp_id` sequence 0,1,0,1, with `rsp_out` 01,02,01,02, and accepts exactly 3 cycles apart.
- Fixed priority (FAIR=0): both valid for 4 ops, then req0 drops.
  - Required: the first 4 responses have `rsp_id`=0; req1 is accepted on the first IDLE cycle after req0 drops.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises, with req1 valid and new a=8'hFF.
  - Required: rsp fields stable and `rsp_valid` held high.
  - Required: `req0_ready`=`req1_ready`=0 and `alu_a` unchanged until `rsp_ready` is raised.
- Reset during EXEC: pulse `rst_n` low mid-cycle.
  - Required: outputs reach their reset values immediately.
  - Required: after release, no `rsp_valid` appears until a new request is made, and `op_count`=0.
- Counter wrap (CNT_W=4): 17 back-to-back operations.
  - Required: `op_count` reads 0 after the 16th response and 1 after the 17th.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Signal bundle tying two requesters, the shared combinational ALU and the
// response consumer to alu_arbiter. The arbiter takes the slave side.
interface alu_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [7:0]       req0_a;
  logic [7:0]       req0_b;
  logic [2:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [7:0]       req1_a;
  logic [7:0]       req1_b;
  logic [2:0]       req1_op;

  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_op;
  logic [7:0]       alu_out;
  logic [7:0]       alu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [7:0]       rsp_out;
  logic [7:0]       rsp_flags;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_out, alu_flags,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_out, rsp_flags, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_out, alu_flags,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_out, rsp_flags, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters: grant, drive
// the ALU from registered operands, capture its result, return it with backpressure.
module alu_arbiter #(
  parameter bit FAIR  = 1'b1,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             last_q;
  logic             id_q;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic             rsp_done;

  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic [2:0]       alu_op_q;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [7:0]       rsp_out_q;
  logic [7:0]       rsp_flags_q;
  logic [CNT_W-1:0] op_count_q;

  // With both requesters valid, FAIR hands the grant to whoever was not served
  // last; otherwise req0 wins. A lone valid requester is always granted.
  always_comb begin : grant_logic
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = FAIR ? ~last_q : 1'b0;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  assign accept   = (state_q == IDLE) && grant_valid;
  assign rsp_done = (state_q == RESP) && bus.rsp_ready;

  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept &&  grant_id;

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:                  state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Operand registers feed the ALU directly; they move only on a grant so the
  // ALU sees stable inputs for the whole operation and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin : operand_reg
    if (!rst_n) begin
      alu_a_q  <= 8'h00;
      alu_b_q  <= 8'h00;
      alu_op_q <= 3'd0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
    end else if (accept) begin
      alu_a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
      alu_b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
      alu_op_q <= grant_id ? bus.req1_op : bus.req0_op;
      id_q     <= grant_id;
      last_q   <= grant_id;
    end
  end

  // The ALU result is sampled only on the EXEC->RESP edge and then held until
  // the next operation reaches that edge, independent of rsp_ready.
  always_ff @(posedge clk or negedge rst_n) begin : response_reg
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= 8'h00;
      rsp_flags_q <= 8'h00;
      op_count_q  <= '0;
    end else if (state_q == EXEC) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= id_q;
      rsp_out_q   <= bus.alu_out;
      rsp_flags_q <= bus.alu_flags;
    end else if (rsp_done) begin
      rsp_valid_q <= 1'b0;
      op_count_q  <= op_count_q + CNT_W'(1);
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.op_count  = op_count_q;

  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.req0_ready && bus.req1_ready));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid_q && !bus.rsp_ready) |=>
      (rsp_valid_q && $stable(rsp_out_q) && $stable(rsp_flags_q) && $stable(rsp_id_q)));

  a_valid_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid_q == (state_q == RESP));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checked every cycle on two
// instances (round-robin with a 4-bit counter, fixed priority) plus directed vectors.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter_if #(.CNT_W(4))  bus_f ();
  alu_arbiter_if #(.CNT_W(16)) bus_x ();

  alu_arbiter #(.FAIR(1'b1), .CNT_W(4))  u_fair  (.clk(clk), .rst_n(rst_n), .bus(bus_f));
  alu_arbiter #(.FAIR(1'b0), .CNT_W(16)) u_fixed (.clk(clk), .rst_n(rst_n), .bus(bus_x));

  // ALU stubs
  assign bus_f.alu_out   = bus_f.alu_a ^ bus_f.alu_b;
  assign bus_f.alu_flags = {5'b0, bus_f.alu_op};
  assign bus_x.alu_out   = bus_x.alu_a ^ bus_x.alu_b;
  assign bus_x.alu_flags = {5'b0, bus_x.alu_op};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_f[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        v0, r0, v1, r1;
    logic [7:0]  a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        rv, rr, rid;
    logic [7:0]  rout, rflags;
    logic [31:0] cnt;
  } snap_t;

  // Model state per instance (0 = fair, 1 = fixed). age: -1 free, 1 executing, 2 responding.
  int         age[2]     = '{-1, -1};
  bit         last_m[2]  = '{1'b1, 1'b1};
  logic [7:0] ea[2]      = '{8'h00, 8'h00};
  logic [7:0] eb[2]      = '{8'h00, 8'h00};
  logic [2:0] eop[2]     = '{3'd0, 3'd0};
  bit         e_rv[2]    = '{1'b0, 1'b0};
  bit         e_id[2]    = '{1'b0, 1'b0};
  logic [7:0] e_out[2]   = '{8'h00, 8'h00};
  logic [7:0] e_flags[2] = '{8'h00, 8'h00};
  int         e_cnt[2]   = '{0, 0};
  bit         p_id[2]    = '{1'b0, 1'b0};
  logic [7:0] p_out[2]   = '{8'h00, 8'h00};
  logic [7:0] p_flags[2] = '{8'h00, 8'h00};

  task automatic model_step(input int k, input snap_t s);
    string p;
    bit    free, gv, gid;
    p = (k == 0) ? "fair" : "fixed";
    if (!rst_n) begin
      age[k] = -1; last_m[k] = 1'b1; ea[k] = 8'h00; eb[k] = 8'h00; eop[k] = 3'd0;
      e_rv[k] = 1'b0; e_id[k] = 1'b0; e_out[k] = 8'h00; e_flags[k] = 8'h00; e_cnt[k] = 0;
    end
    free = (age[k] < 0);
    gv   = s.v0 || s.v1;
    if (s.v0 && s.v1) gid = (k == 0) ? (last_m[k] == 1'b0) : 1'b0;
    else              gid = s.v1;

    check({p, "_req0_ready"}, s.r0, free && gv && !gid);
    check({p, "_req1_ready"}, s.r1, free && gv && gid);
    check({p, "_alu_a"},      s.alu_a, ea[k]);
    check({p, "_alu_b"},      s.alu_b, eb[k]);
    check({p, "_alu_op"},     s.alu_op, eop[k]);
    check({p, "_rsp_valid"},  s.rv, e_rv[k]);
    check({p, "_rsp_id"},     s.rid, e_id[k]);
    check({p, "_rsp_out"},    s.rout, e_out[k]);
    check({p, "_rsp_flags"},  s.rflags, e_flags[k]);
    check({p, "_op_count"},   s.cnt, e_cnt[k]);

    if (rst_n) begin
      if (free && gv) begin
        ea[k]      = gid ? s.a1 : s.a0;
        eb[k]      = gid ? s.b1 : s.b0;
        eop[k]     = gid ? s.op1 : s.op0;
        last_m[k]  = gid;
        p_id[k]    = gid;
        p_out[k]   = ea[k] ^ eb[k];
        p_flags[k] = {5'b0, eop[k]};
        age[k]     = 1;
        if (k == 0) acc_f.push_back(cyc);
      end else if (age[k] == 1) begin
        e_rv[k] = 1'b1; e_id[k] = p_id[k]; e_out[k] = p_out[k]; e_flags[k] = p_flags[k];
        age[k]  = 2;
      end else if (age[k] == 2 && s.rr) begin
        e_rv[k]  = 1'b0;
        e_cnt[k] = (e_cnt[k] + 1) % ((k == 0) ? 16 : 65536);
        age[k]   = -1;
      end
    end
  endtask

  always @(negedge clk) begin : compare
    snap_t s;
    cyc++;
    s.v0 = bus_f.req0_valid; s.r0 = bus_f.req0_ready; s.a0 = bus_f.req0_a; s.b0 = bus_f.req0_b;
    s.op0 = bus_f.req0_op;   s.v1 = bus_f.req1_valid; s.r1 = bus_f.req1_ready; s.a1 = bus_f.req1_a;
    s.b1 = bus_f.req1_b;     s.op1 = bus_f.req1_op;   s.alu_a = bus_f.alu_a; s.alu_b = bus_f.alu_b;
    s.alu_op = bus_f.alu_op; s.rv = bus_f.rsp_valid;  s.rr = bus_f.rsp_ready; s.rid = bus_f.rsp_id;
    s.rout = bus_f.rsp_out;  s.rflags = bus_f.rsp_flags; s.cnt = 32'(bus_f.op_count);
    model_step(0, s);
    s.v0 = bus_x.req0_valid; s.r0 = bus_x.req0_ready; s.a0 = bus_x.req0_a; s.b0 = bus_x.req0_b;
    s.op0 = bus_x.req0_op;   s.v1 = bus_x.req1_valid; s.r1 = bus_x.req1_ready; s.a1 = bus_x.req1_a;
    s.b1 = bus_x.req1_b;     s.op1 = bus_x.req1_op;   s.alu_a = bus_x.alu_a; s.alu_b = bus_x.alu_b;
    s.alu_op = bus_x.alu_op; s.rv = bus_x.rsp_valid;  s.rr = bus_x.rsp_ready; s.rid = bus_x.rsp_id;
    s.rout = bus_x.rsp_out;  s.rflags = bus_x.rsp_flags; s.cnt = 32'(bus_x.op_count);
    model_step(1, s);
  end

  // Waits for a response to be taken; returns just after the consuming edge.
  task automatic wait_rsp(input int k, output logic id, output logic [7:0] out);
    bit ok = 1'b0;
    id = 1'b0; out = 8'h00;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (k == 0 && bus_f.rsp_valid && bus_f.rsp_ready) begin
        id = bus_f.rsp_id; out = bus_f.rsp_out; ok = 1'b1;
      end
      if (k == 1 && bus_x.rsp_valid && bus_x.rsp_ready) begin
        id = bus_x.rsp_id; out = bus_x.rsp_out; ok = 1'b1;
      end
    end
    check("rsp_wait", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  // Waits for a request handshake; returns just after the accepting edge.
  task automatic wait_accept(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (k == 0) ok = (bus_f.req0_valid && bus_f.req0_ready) || (bus_f.req1_valid && bus_f.req1_ready);
      else        ok = (bus_x.req0_valid && bus_x.req0_ready) || (bus_x.req1_valid && bus_x.req1_ready);
    end
    check("accept_wait", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic       id;
  logic [7:0] out;
  bit         seen;

  initial begin
    bus_f.req0_valid = 0; bus_f.req0_a = 0; bus_f.req0_b = 0; bus_f.req0_op = 0;
    bus_f.req1_valid = 0; bus_f.req1_a = 0; bus_f.req1_b = 0; bus_f.req1_op = 0;
    bus_f.rsp_ready  = 0;
    bus_x.req0_valid = 0; bus_x.req0_a = 0; bus_x.req0_b = 0; bus_x.req0_op = 0;
    bus_x.req1_valid = 0; bus_x.req1_a = 0; bus_x.req1_b = 0; bus_x.req1_op = 0;
    bus_x.rsp_ready  = 0;

    // Reset values, before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", bus_f.rsp_valid, 1'b0);
    check("rst_alu_a", bus_f.alu_a, 8'h00);
    check("rst_op_count", bus_f.op_count, 4'd0);
    bus_f.req0_valid = 1; bus_f.req1_valid = 1;
    #1;
    check("rst_grant_req0", bus_f.req0_ready, 1'b1);
    check("rst_grant_req1", bus_f.req1_ready, 1'b0);
    bus_f.req0_valid = 0; bus_f.req1_valid = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single operation
    bus_f.rsp_ready = 1;
    bus_f.req0_a = 8'h12; bus_f.req0_b = 8'h34; bus_f.req0_op = 3'd2; bus_f.req0_valid = 1;
    #1 check("single_accept_ready", bus_f.req0_ready, 1'b1);
    @(posedge clk); #1;
    bus_f.req0_valid = 0;
    check("single_exec_valid", bus_f.rsp_valid, 1'b0);
    @(posedge clk); #1;
    check("single_rsp_valid", bus_f.rsp_valid, 1'b1);
    check("single_rsp_out", bus_f.rsp_out, 8'h26);
    check("single_rsp_flags", bus_f.rsp_flags, 8'h02);
    check("single_rsp_id", bus_f.rsp_id, 1'b0);
    @(posedge clk); #1;
    check("single_op_count", bus_f.op_count, 4'd1);

    // Round-robin and counter wrap: 17 back-to-back operations
    do_reset();
    acc_f.delete();
    bus_f.req0_a = 8'h01; bus_f.req0_b = 8'h00; bus_f.req0_op = 3'd0;
    bus_f.req1_a = 8'h02; bus_f.req1_b = 8'h00; bus_f.req1_op = 3'd0;
    bus_f.req0_valid = 1; bus_f.req1_valid = 1; bus_f.rsp_ready = 1;
    for (int n = 1; n <= 17; n++) begin
      wait_rsp(0, id, out);
      if (n <= 4) begin
        check("rr_id", id, (n % 2 == 0) ? 1'b1 : 1'b0);
        check("rr_out", out, (n % 2 == 0) ? 8'h02 : 8'h01);
      end
      if (n == 16) check("wrap_count_16", bus_f.op_count, 4'd0);
      if (n == 17) begin
        check("wrap_count_17", bus_f.op_count, 4'd1);
        bus_f.req0_valid = 0; bus_f.req1_valid = 0;
      end
    end
    check("rr_accepts", acc_f.size(), 17);
    if (acc_f.size() >= 4)
      for (int i = 1; i < 4; i++) check("rr_spacing", acc_f[i] - acc_f[i-1], 3);

    // Fixed priority
    bus_x.req0_a = 8'h0A; bus_x.req0_b = 8'h01; bus_x.req0_op = 3'd5;
    bus_x.req1_a = 8'h0B; bus_x.req1_b = 8'h01; bus_x.req1_op = 3'd5;
    bus_x.req0_valid = 1; bus_x.req1_valid = 1; bus_x.rsp_ready = 1;
    for (int n = 1; n <= 4; n++) begin
      wait_rsp(1, id, out);
      check("fixed_id", id, 1'b0);
      check("fixed_out", out, 8'h0B);
    end
    bus_x.req0_valid = 0;
    #1 check("fixed_req1_ready", bus_x.req1_ready, 1'b1);
    wait_rsp(1, id, out);
    bus_x.req1_valid = 0;
    check("fixed_req1_id", id, 1'b1);
    check("fixed_req1_out", out, 8'h0A);

    // Backpressure
    bus_f.rsp_ready = 0;
    bus_f.req0_a = 8'h10; bus_f.req0_b = 8'h05; bus_f.req0_op = 3'd3; bus_f.req0_valid = 1;
    wait_accept(0);
    bus_f.req0_valid = 0;
    @(posedge clk); #1;
    check("bp_valid_rise", bus_f.rsp_valid, 1'b1);
    bus_f.req1_a = 8'hFF; bus_f.req1_b = 8'h0F; bus_f.req1_op = 3'd6; bus_f.req1_valid = 1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", bus_f.rsp_valid, 1'b1);
      check("bp_out", bus_f.rsp_out, 8'h15);
      check("bp_flags", bus_f.rsp_flags, 8'h03);
      check("bp_id", bus_f.rsp_id, 1'b0);
      check("bp_req_ready", {bus_f.req0_ready, bus_f.req1_ready}, 2'b00);
      check("bp_alu_a", bus_f.alu_a, 8'h10);
    end
    @(posedge clk); #1;
    bus_f.rsp_ready = 1;
    wait_rsp(0, id, out);
    check("bp_first_out", out, 8'h15);
    wait_rsp(0, id, out);
    bus_f.req1_valid = 0;
    check("bp_second_id", id, 1'b1);
    check("bp_second_out", out, 8'hF0);

    // Reset during EXEC
    bus_f.req0_a = 8'h33; bus_f.req0_b = 8'h11; bus_f.req0_op = 3'd1; bus_f.req0_valid = 1;
    wait_accept(0);
    bus_f.req0_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_exec_valid", bus_f.rsp_valid, 1'b0);
    check("rst_exec_alu", {bus_f.alu_a, bus_f.alu_b, 5'b0, bus_f.alu_op}, 24'h0);
    check("rst_exec_rsp", {bus_f.rsp_id, bus_f.rsp_out, bus_f.rsp_flags}, 17'h0);
    check("rst_exec_count", bus_f.op_count, 4'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus_f.rsp_valid) seen = 1'b1;
    end
    check("rst_no_rsp", seen, 1'b0);
    check("rst_count_after", bus_f.op_count, 4'd0);
    @(posedge clk); #1;
    bus_f.req1_a = 8'h05; bus_f.req1_b = 8'h03; bus_f.req1_op = 3'd7; bus_f.req1_valid = 1;
    wait_rsp(0, id, out);
    bus_f.req1_valid = 0;
    check("post_rst_id", id, 1'b1);
    check("post_rst_out", out, 8'h06);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
